// File: rtl/fir_s2p_3.sv
// fir_s2p_3 -- serial-to-parallel front end for the 3-way unfolded FIR.
// Packs three consecutive valid samples into one parallel word with a
// one-cycle strobe. FLUSH closes out a partial group, padding missing lanes
// with zero. All outputs are registered; no input reaches an output
// combinationally.
//
// Ports:
//   CLK           system clock, rising edge
//   RST_N         asynchronous active-low reset
//   DIN [WIDTH]   serial input sample (two's complement)
//   VIN           DIN valid this cycle
//   FLUSH         emit pending partial group, zero-padded
//   DOUT0..2      packed group, DOUT0 oldest, DOUT2 newest
//   VOUT          one-cycle strobe for a new group on DOUT0..2
//   PHASE [2]     samples currently buffered (0..2)

// One output lane register: loads on an emission, otherwise holds.
module fir_s2p_3_lane #(
  parameter int WIDTH = 13
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (ld) dout_d = d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign q = dout_q;
endmodule

module fir_s2p_3 #(
  parameter int WIDTH = 13
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VIN,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] DOUT0,
  output logic [WIDTH-1:0] DOUT1,
  output logic [WIDTH-1:0] DOUT2,
  output logic             VOUT,
  output logic [1:0]       PHASE
);
  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} ph_e;

  ph_e                               ph_q, ph_d;
  logic [WIDTH-1:0]                  b0_q, b0_d, b1_q, b1_d;
  logic                              vout_q;
  logic                              emit;
  logic [NUM_LANES-1:0][WIDTH-1:0]   lane_d;
  logic [NUM_LANES-1:0][WIDTH-1:0]   dout_q;

  always_comb begin
    ph_d   = ph_q;
    b0_d   = b0_q;
    b1_d   = b1_q;
    emit   = 1'b0;
    lane_d = '0;
    case (ph_q)
      S0: begin
        if (VIN) begin
          if (FLUSH) begin
            emit      = 1'b1;
            lane_d[0] = DIN;
          end else begin
            b0_d = DIN;
            ph_d = S1;
          end
        end
      end
      S1: begin
        if (FLUSH) begin
          emit      = 1'b1;
          lane_d[0] = b0_q;
          if (VIN) lane_d[1] = DIN;
        end else if (VIN) begin
          b1_d = DIN;
          ph_d = S2;
        end
      end
      S2: begin
        // A valid sample here completes the group whether or not FLUSH is up.
        if (VIN || FLUSH) begin
          emit      = 1'b1;
          lane_d[0] = b0_q;
          lane_d[1] = b1_q;
          if (VIN) lane_d[2] = DIN;
        end
      end
      default: begin
        // Unreachable encoding: recover to empty, drop buffered data.
        ph_d = S0;
        b0_d = '0;
        b1_d = '0;
      end
    endcase
    // Every emission leaves the block empty with clean buffers.
    if (emit) begin
      ph_d = S0;
      b0_d = '0;
      b1_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ph_q   <= S0;
      b0_q   <= '0;
      b1_q   <= '0;
      vout_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      b0_q   <= b0_d;
      b1_q   <= b1_d;
      vout_q <= emit;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fir_s2p_3_lane #(.WIDTH(WIDTH)) u_lane (
      .CLK   (CLK),
      .RST_N (RST_N),
      .ld    (emit),
      .d     (lane_d[g]),
      .q     (dout_q[g])
    );
  end

  assign DOUT0 = dout_q[0];
  assign DOUT1 = dout_q[1];
  assign DOUT2 = dout_q[2];
  assign VOUT  = vout_q;
  assign PHASE = ph_q;
endmodule

// File: tb/tb_fir_s2p_3.sv
module tb_fir_s2p_3;
  localparam int W = 13;

  logic                CLK, RST_N, VIN, FLUSH;
  logic signed [W-1:0] DIN;
  logic signed [W-1:0] DOUT0, DOUT1, DOUT2;
  logic                VOUT;
  logic [1:0]          PHASE;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending samples, last emitted group.
  logic signed [W-1:0] pend[$];
  logic signed [W-1:0] exp_d[3];
  logic                exp_v;

  fir_s2p_3 #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .VIN(VIN), .FLUSH(FLUSH),
    .DOUT0(DOUT0), .DOUT1(DOUT1), .DOUT2(DOUT2), .VOUT(VOUT), .PHASE(PHASE)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < 3; i++) exp_d[i] = '0;
    exp_v = 0;
  endtask

  // Drive one cycle, advance to 1 time unit past the edge, update model.
  task automatic step(input logic v, input logic signed [W-1:0] d, input logic f);
    VIN = v; DIN = d; FLUSH = f;
    @(posedge CLK); #1;
    exp_v = 0;
    if (v) pend.push_back(d);
    if (pend.size() == 3 || (f && pend.size() > 0)) begin
      exp_v = 1;
      for (int i = 0; i < 3; i++) exp_d[i] = (i < pend.size()) ? pend[i] : '0;
      pend.delete();
    end
    VIN = 0; FLUSH = 0; DIN = '0;
  endtask

  task automatic test_reset();
    RST_N = 0; VIN = 0; FLUSH = 0; DIN = '0;
    model_reset();
    #12;
    total++;
    if ({DOUT0, DOUT1, DOUT2} !== '0 || VOUT !== 1'b0 || PHASE !== 2'd0) begin
      bad++;
      $display("FAIL reset: dout=%0d,%0d,%0d vout=%b phase=%0d want all 0",
               DOUT0, DOUT1, DOUT2, VOUT, PHASE);
    end
    @(negedge CLK); RST_N = 1;
  endtask

  task automatic test_stream();
    logic signed [W-1:0] din[6];
    logic [1:0] ph[6];
    logic v[6];
    din = '{13'sd1, 13'sd2, 13'sd3, 13'sd4, 13'sd5, -13'sd6};
    ph  = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    v   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(1, din[i], 0);
      total++;
      if (VOUT !== v[i] || PHASE !== ph[i]) begin
        bad++;
        $display("FAIL stream[%0d]: vout=%b phase=%0d want vout=%b phase=%0d",
                 i, VOUT, PHASE, v[i], ph[i]);
      end
      if (v[i]) begin
        total++;
        if (DOUT0 !== din[i-2] || DOUT1 !== din[i-1] || DOUT2 !== din[i]) begin
          bad++;
          $display("FAIL stream_data[%0d]: got %0d,%0d,%0d want %0d,%0d,%0d",
                   i, DOUT0, DOUT1, DOUT2, din[i-2], din[i-1], din[i]);
        end
      end
    end
  endtask

  task automatic test_gapped();
    logic vs[6];
    logic signed [W-1:0] ds[6];
    vs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ds = '{13'sd10, 13'sd0, 13'sd0, 13'sd20, 13'sd0, 13'sd30};
    for (int i = 0; i < 5; i++) begin
      step(vs[i], ds[i], 0);
      total++;
      if (VOUT !== 1'b0 || DOUT0 !== 13'sd4 || DOUT1 !== 13'sd5 || DOUT2 !== -13'sd6) begin
        bad++;
        $display("FAIL gap_hold[%0d]: vout=%b dout=%0d,%0d,%0d want 0 and 4,5,-6",
                 i, VOUT, DOUT0, DOUT1, DOUT2);
      end
    end
    step(vs[5], ds[5], 0);
    total++;
    if (VOUT !== 1'b1 || DOUT0 !== 13'sd10 || DOUT1 !== 13'sd20 || DOUT2 !== 13'sd30) begin
      bad++;
      $display("FAIL gap_emit: vout=%b dout=%0d,%0d,%0d want 1 and 10,20,30",
               VOUT, DOUT0, DOUT1, DOUT2);
    end
    step(0, 0, 0);
    total++;
    if (VOUT !== 1'b0) begin
      bad++;
      $display("FAIL gap_strobe_len: vout=%b want 0", VOUT);
    end
  endtask

  task automatic test_flush();
    step(1, 13'sd7, 0);
    step(0, 0, 1);
    total++;
    if (VOUT !== 1'b1 || DOUT0 !== 13'sd7 || DOUT1 !== 0 || DOUT2 !== 0 || PHASE !== 0) begin
      bad++;
      $display("FAIL flush_s1: vout=%b dout=%0d,%0d,%0d ph=%0d want 1 7,0,0 0",
               VOUT, DOUT0, DOUT1, DOUT2, PHASE);
    end
    step(1, 13'sd8, 0);
    step(1, 13'sd9, 1);
    total++;
    if (VOUT !== 1'b1 || DOUT0 !== 13'sd8 || DOUT1 !== 13'sd9 || DOUT2 !== 0 || PHASE !== 0) begin
      bad++;
      $display("FAIL flush_s1_vin: vout=%b dout=%0d,%0d,%0d ph=%0d want 1 8,9,0 0",
               VOUT, DOUT0, DOUT1, DOUT2, PHASE);
    end
    step(0, 0, 1);
    total++;
    if (VOUT !== 1'b0 || DOUT0 !== 13'sd8 || DOUT1 !== 13'sd9 || PHASE !== 0) begin
      bad++;
      $display("FAIL flush_s0_idle: vout=%b dout=%0d,%0d ph=%0d want 0 8,9 0",
               VOUT, DOUT0, DOUT1, PHASE);
    end
    // Two-sample partial group flushed with no new sample.
    step(1, 13'sd21, 0);
    step(1, 13'sd22, 0);
    step(0, 0, 1);
    total++;
    if (VOUT !== 1'b1 || DOUT0 !== 13'sd21 || DOUT1 !== 13'sd22 || DOUT2 !== 0) begin
      bad++;
      $display("FAIL flush_s2: vout=%b dout=%0d,%0d,%0d want 1 21,22,0",
               VOUT, DOUT0, DOUT1, DOUT2);
    end
  endtask

  task automatic test_extremes();
    step(1, -13'sd4096, 0);
    step(1, 13'sd4095, 0);
    step(1, 13'sd0, 0);
    total++;
    if (VOUT !== 1'b1 || DOUT0 !== -13'sd4096 || DOUT1 !== 13'sd4095 || DOUT2 !== 0) begin
      bad++;
      $display("FAIL extremes: vout=%b dout=%0d,%0d,%0d want 1 -4096,4095,0",
               VOUT, DOUT0, DOUT1, DOUT2);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 13'sd11, 0);
    step(1, 13'sd12, 0);
    #2 RST_N = 0;
    #1;
    model_reset();
    total++;
    if ({DOUT0, DOUT1, DOUT2} !== '0 || VOUT !== 1'b0 || PHASE !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: dout=%0d,%0d,%0d vout=%b phase=%0d want all 0",
               DOUT0, DOUT1, DOUT2, VOUT, PHASE);
    end
    @(negedge CLK); RST_N = 1;
    step(1, 13'sd13, 0);
    step(1, 13'sd14, 0);
    step(1, 13'sd15, 0);
    total++;
    if (VOUT !== 1'b1 || DOUT0 !== 13'sd13 || DOUT1 !== 13'sd14 || DOUT2 !== 13'sd15) begin
      bad++;
      $display("FAIL reset_recover: vout=%b dout=%0d,%0d,%0d want 1 13,14,15",
               VOUT, DOUT0, DOUT1, DOUT2);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 13'sd1, 0);
    step(1, 13'sd2, 0);
    step(1, 13'sd3, 0);
    total++;
    if (VOUT !== 1'b1 || DOUT0 !== 13'sd1 || DOUT1 !== 13'sd2 || DOUT2 !== 13'sd3) begin
      bad++;
      $display("FAIL b2b_first: vout=%b dout=%0d,%0d,%0d want 1 1,2,3",
               VOUT, DOUT0, DOUT1, DOUT2);
    end
    step(1, 13'sd4, 1);
    total++;
    if (VOUT !== 1'b1 || DOUT0 !== 13'sd4 || DOUT1 !== 0 || DOUT2 !== 0) begin
      bad++;
      $display("FAIL b2b_second: vout=%b dout=%0d,%0d,%0d want 1 4,0,0",
               VOUT, DOUT0, DOUT1, DOUT2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 70), W'($urandom), ($urandom_range(99) < 10));
      total++;
      if (VOUT !== exp_v || DOUT0 !== exp_d[0] || DOUT1 !== exp_d[1] ||
          DOUT2 !== exp_d[2] || PHASE !== 2'(pend.size())) begin
        bad++;
        $display("FAIL random[%0d]: vout=%b dout=%0d,%0d,%0d ph=%0d want %b %0d,%0d,%0d %0d",
                 i, VOUT, DOUT0, DOUT1, DOUT2, PHASE,
                 exp_v, exp_d[0], exp_d[1], exp_d[2], pend.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gapped();
    test_flush();
    test_extremes();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
